// File: rtl/hamming_pkg.sv
// Shared types, widths and pure Hamming (12,8) SEC functions for the scheduler and its engine.
// Codeword bit i-1 holds Hamming position i; parity sits at positions 1, 2, 4 and 8.
package hamming_pkg;
    localparam int CW_W  = 12;
    localparam int D_W   = 8;
    localparam int SYN_W = 4;

    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    // Each mask selects every position whose index has the matching bit set.
    localparam logic [CW_W-1:0] M1 = 12'h555;
    localparam logic [CW_W-1:0] M2 = 12'h666;
    localparam logic [CW_W-1:0] M4 = 12'h878;
    localparam logic [CW_W-1:0] M8 = 12'hF80;

    typedef enum logic { SRC_ENC = 1'b0, SRC_DEC = 1'b1 } src_t;
    typedef enum logic [1:0] { ST_IDLE, ST_BUSY, ST_RESP } state_t;

    typedef struct packed {
        src_t             src;
        logic [CW_W-1:0]  code;
        logic [D_W-1:0]   data;
        logic [SYN_W-1:0] syndrome;
        logic             corrected;
        logic             uncorr;
    } result_t;

    function automatic logic [CW_W-1:0] ham_encode(input logic [D_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic p1, p2, p4, p8;
        cw = {d[7:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
        p1 = ^(cw & M1);
        p2 = ^(cw & M2);
        p4 = ^(cw & M4);
        p8 = ^(cw & M8);
        cw[P1_POS-1] = p1;
        cw[P2_POS-1] = p2;
        cw[P4_POS-1] = p4;
        cw[P8_POS-1] = p8;
        return cw;
    endfunction

    function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CW_W-1:0] cw);
        return {^(cw & M8), ^(cw & M4), ^(cw & M2), ^(cw & M1)};
    endfunction

    function automatic logic [D_W-1:0] ham_extract(input logic [CW_W-1:0] cw);
        return {cw[11:8], cw[6:4], cw[2]};
    endfunction
endpackage

// File: rtl/hamming_sched_if.sv
// Request, grant and response bundle between the requesters/consumer and the scheduler.
interface hamming_sched_if import hamming_pkg::*; ();
    logic                enc_req;
    logic [D_W-1:0]      enc_data;
    logic                enc_gnt;
    logic                dec_req;
    logic [CW_W-1:0]     dec_cw;
    logic                dec_gnt;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_src;
    logic [CW_W-1:0]     rsp_code;
    logic [D_W-1:0]      rsp_data;
    logic [SYN_W-1:0]    rsp_syndrome;
    logic                rsp_corrected;
    logic                rsp_uncorr;
    logic                busy;
    logic [7:0]          err_count;

    modport master (
        output enc_req, enc_data, dec_req, dec_cw, rsp_ready,
        input  enc_gnt, dec_gnt, rsp_valid, rsp_src, rsp_code, rsp_data,
               rsp_syndrome, rsp_corrected, rsp_uncorr, busy, err_count
    );

    modport slave (
        input  enc_req, enc_data, dec_req, dec_cw, rsp_ready,
        output enc_gnt, dec_gnt, rsp_valid, rsp_src, rsp_code, rsp_data,
               rsp_syndrome, rsp_corrected, rsp_uncorr, busy, err_count
    );
endinterface

// File: rtl/hamming_engine.sv
// LAT-stage Hamming (12,8) pipeline: the first stage computes encode or decode on load,
// later stages only delay the result so the scheduler sees it after a fixed latency.
module hamming_engine
    import hamming_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            i_load,
    input  src_t            i_op,
    input  logic [CW_W-1:0] i_payload,
    output result_t         o_result
);
    result_t          w_result;
    logic [SYN_W-1:0] w_syn;
    logic [CW_W-1:0]  w_fixed;
    result_t          r_pipe [LAT];

    always_comb begin
        w_result = '0;
        w_syn    = ham_syndrome(i_payload);
        w_fixed  = i_payload;
        w_result.src = i_op;
        if (i_op == SRC_ENC) begin
            w_result.code = ham_encode(i_payload[D_W-1:0]);
            w_result.data = i_payload[D_W-1:0];
        end else begin
            if (w_syn >= 4'd1 && w_syn <= 4'd12) begin
                w_fixed[w_syn - 4'd1] = ~i_payload[w_syn - 4'd1];
            end
            w_result.code      = w_fixed;
            w_result.data      = ham_extract(w_fixed);
            w_result.syndrome  = w_syn;
            w_result.corrected = (w_syn >= 4'd1) && (w_syn <= 4'd12);
            w_result.uncorr    = (w_syn >= 4'd13);
        end
    end

    // NOTE: pure datapath stages carry no reset; the scheduler never consumes them
    // before a load has flowed through, so resetting them would only add routing.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_pipe[0] <= w_result;
        end
        for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_result = r_pipe[LAT-1];
endmodule

// File: rtl/hamming_sched.sv
// Round-robin scheduler sharing one Hamming engine between an encode and a decode requester,
// returning each result on a valid/ready port and counting decode errors.
module hamming_sched
    import hamming_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    hamming_sched_if.slave     bus
);
    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t          r_state;
    src_t            r_prio;
    logic [2:0]      r_cnt;
    result_t         r_rsp;
    logic [7:0]      r_err_count;

    logic            w_idle;
    logic            w_enc_gnt;
    logic            w_dec_gnt;
    logic            w_load;
    src_t            w_op;
    logic [CW_W-1:0] w_payload;
    result_t         w_eng;

    // NOTE: grants are combinational so the payload is captured on the accept edge;
    // gating with rst keeps them low while the block is held in reset.
    assign w_idle    = (r_state == ST_IDLE) && !rst;
    assign w_enc_gnt = w_idle && bus.enc_req && (!bus.dec_req || r_prio == SRC_ENC);
    assign w_dec_gnt = w_idle && bus.dec_req && (!bus.enc_req || r_prio == SRC_DEC);
    assign w_load    = w_enc_gnt || w_dec_gnt;
    assign w_op      = w_dec_gnt ? SRC_DEC : SRC_ENC;
    assign w_payload = w_dec_gnt ? bus.dec_cw : {{(CW_W-D_W){1'b0}}, bus.enc_data};

    hamming_engine #(.LAT(LAT)) u_engine (
        .clk       (clk),
        .i_load    (w_load),
        .i_op      (w_op),
        .i_payload (w_payload),
        .o_result  (w_eng)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prio      <= SRC_ENC;
            r_cnt       <= '0;
            r_rsp       <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= 3'd1;
                        r_prio  <= w_dec_gnt ? SRC_ENC : SRC_DEC;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == LAT_C) begin
                        r_state <= ST_RESP;
                        r_rsp   <= w_eng;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= ST_IDLE;
                        if (r_rsp.src == SRC_DEC && r_rsp.syndrome != '0 && r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.enc_gnt       = w_enc_gnt;
    assign bus.dec_gnt       = w_dec_gnt;
    assign bus.rsp_valid     = (r_state == ST_RESP);
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.rsp_src       = r_rsp.src;
    assign bus.rsp_code      = r_rsp.code;
    assign bus.rsp_data      = r_rsp.data;
    assign bus.rsp_syndrome  = r_rsp.syndrome;
    assign bus.rsp_corrected = r_rsp.corrected;
    assign bus.rsp_uncorr    = r_rsp.uncorr;
    assign bus.err_count     = r_err_count;
endmodule
